// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and the load/store unit.
// Multi-byte accesses are serialised into byte cycles, little-endian, with alternating priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_cancel_i,
    output logic              if_done_o,
    output logic [DATA_W-1:0] if_inst_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              mem_done_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    input  logic [7:0]        ram_din_i,
    output logic [7:0]        ram_dout_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [1:0]        nm1_q, nm1_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;
    logic              if_done_q, if_done_d;
    logic [DATA_W-1:0] if_inst_q, if_inst_d;
    logic              mem_done_q, mem_done_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic              if_ok;
    logic              grant_mem;
    logic [4:0]        rd_bidx;
    logic [4:0]        wr_bidx;

    // cnt_q counts edges since acceptance; a read byte lags its address by two edges
    assign rd_bidx = {cnt_q[1:0] - 2'd1, 3'b000};
    assign wr_bidx = {cnt_q[1:0] + 2'd1, 3'b000};

    assign if_ok     = if_req_i & ~if_cancel_i;
    assign grant_mem = mem_req_i & (~if_ok | (last_q == OWN_IF));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        nm1_d       = nm1_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = ram_wr_q;
        if_done_d   = if_done_q;
        if_inst_d   = if_inst_q;
        mem_done_d  = mem_done_q;
        mem_rdata_d = mem_rdata_q;

        if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (grant_mem) begin
                        owner_d    = OWN_MEM;
                        last_d     = OWN_MEM;
                        nm1_d      = (mem_len_i == 2'b00) ? 2'd0 :
                                     (mem_len_i == 2'b01) ? 2'd1 : 2'd3;
                        cnt_d      = 3'd0;
                        base_d     = mem_addr_i;
                        wdata_d    = mem_wdata_i;
                        asm_d      = '0;
                        ram_a_d    = mem_addr_i;
                        ram_dout_d = mem_wdata_i[7:0];
                        ram_wr_d   = mem_we_i;
                        state_d    = mem_we_i ? WRITE : READ;
                    end else if (if_ok) begin
                        owner_d  = OWN_IF;
                        last_d   = OWN_IF;
                        nm1_d    = 2'd3;
                        cnt_d    = 3'd0;
                        base_d   = if_addr_i;
                        asm_d    = '0;
                        ram_a_d  = if_addr_i;
                        ram_wr_d = 1'b0;
                        state_d  = READ;
                    end
                end
                READ: begin
                    if (owner_q == OWN_IF && if_cancel_i) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q < {1'b0, nm1_q}) begin
                            ram_a_d = base_q + ADDR_W'(cnt_q + 3'd1);
                        end
                        if (cnt_q != 3'd0) begin
                            asm_d[rd_bidx +: 8] = ram_din_i;
                        end
                        if (cnt_q == {1'b0, nm1_q} + 3'd1) begin
                            state_d = DONE;
                            if (owner_q == OWN_IF) begin
                                if_done_d = 1'b1;
                                if_inst_d = asm_d;
                            end else begin
                                mem_done_d  = 1'b1;
                                mem_rdata_d = asm_d;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (cnt_q < {1'b0, nm1_q}) begin
                        cnt_d      = cnt_q + 3'd1;
                        ram_a_d    = base_q + ADDR_W'(cnt_q + 3'd1);
                        ram_dout_d = wdata_q[wr_bidx +: 8];
                    end else begin
                        ram_wr_d   = 1'b0;
                        mem_done_d = 1'b1;
                        state_d    = DONE;
                    end
                end
                DONE: begin
                    if_done_d  = 1'b0;
                    mem_done_d = 1'b0;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            last_q      <= OWN_IF;
            nm1_q       <= 2'd0;
            cnt_q       <= 3'd0;
            base_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            ram_a_q     <= '0;
            ram_dout_q  <= 8'd0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            if_inst_q   <= '0;
            mem_done_q  <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            nm1_q       <= nm1_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_done_q   <= if_done_d;
            if_inst_q   <= if_inst_d;
            mem_done_q  <= mem_done_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // the RAM pauses on the same rdy, so a stalled strobe must not reach it
    assign ram_wr_o    = ram_wr_q & rdy;
    assign ram_a_o     = ram_a_q;
    assign ram_dout_o  = ram_dout_q;
    assign if_done_o   = if_done_q;
    assign if_inst_o   = if_inst_q;
    assign mem_done_o  = mem_done_q;
    assign mem_rdata_o = mem_rdata_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-wide RAM model (one-edge read latency).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_cancel_i;
    logic        if_done_o;
    logic [31:0] if_inst_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [1:0]  mem_len_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic [7:0]  ram_din_i = 8'd0;
    logic [7:0]  ram_dout_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    logic [7:0] rom_m [0:65535];
    logic [7:0] wmem  [0:65535];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_cancel_i(if_cancel_i),
        .if_done_o(if_done_o), .if_inst_o(if_inst_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
        .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o), .ram_a_o(ram_a_o),
        .ram_wr_o(ram_wr_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // address seen before edge E is consumed at E; its byte is visible after E
    always @(posedge clk) begin
        if (rdy) begin
            ram_din_i <= rom_m[ram_a_o[15:0]];
            if (ram_wr_o) begin
                wmem[ram_a_o[15:0]] <= ram_dout_o;
                wr_cnt <= wr_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max_cyc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(if_done_o || mem_done_o) && n < max_cyc);
        if (!(if_done_o || mem_done_o)) chk("done_timeout", 32'(n), 32'(max_cyc + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int w0;
        rom_m[16'h1000] = 8'h13; rom_m[16'h1001] = 8'h05;
        rom_m[16'h1002] = 8'h00; rom_m[16'h1003] = 8'h00;
        rom_m[16'h0030] = 8'h80;
        rom_m[16'hFFFF] = 8'h11; rom_m[16'h0000] = 8'h22;

        rst = 1'b0; rdy = 1'b1;
        if_req_i = 0; if_addr_i = 0; if_cancel_i = 0;
        mem_req_i = 0; mem_we_i = 0; mem_len_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
        tick(); tick();
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_wr", 32'(ram_wr_o), 0);
        chk("rst_a", ram_a_o, 0);
        chk("rst_done", {30'd0, if_done_o, mem_done_o}, 0);
        rst = 1'b1;
        tick();

        // 1: 4-byte fetch
        if_addr_i = 32'h1000; if_req_i = 1; tick(); if_req_i = 0;
        chk("t1_a0", ram_a_o, 32'h1000);
        chk("t1_busy", 32'(busy_o), 1);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("t1_a", ram_a_o, 32'h1000 + 32'(k));
        end
        wait_done(10, n);
        chk("t1_lat", 32'(n), 2);
        chk("t1_ifdone", 32'(if_done_o), 1);
        chk("t1_inst", if_inst_o, 32'h00000513);
        chk("t1_memdone", 32'(mem_done_o), 0);
        tick();
        chk("t1_pulse", 32'(if_done_o), 0);
        chk("t1_idle", 32'(busy_o), 0);

        // 2: 2-byte write at odd address
        mem_we_i = 1; mem_len_i = 2'b01; mem_addr_i = 32'h2001; mem_wdata_i = 32'hFFFFABCD;
        w0 = wr_cnt; mem_req_i = 1; tick(); mem_req_i = 0;
        chk("t2_wr0", {23'd0, ram_wr_o, ram_dout_o}, {23'd0, 1'b1, 8'hCD});
        chk("t2_a0", ram_a_o, 32'h2001);
        tick();
        chk("t2_wr1", {23'd0, ram_wr_o, ram_dout_o}, {23'd0, 1'b1, 8'hAB});
        chk("t2_a1", ram_a_o, 32'h2002);
        tick();
        chk("t2_wroff", 32'(ram_wr_o), 0);
        chk("t2_done", 32'(mem_done_o), 1);
        tick();
        chk("t2_wrcnt", 32'(wr_cnt - w0), 2);
        chk("t2_m2001", {24'd0, wmem[16'h2001]}, 32'hCD);
        chk("t2_m2002", {24'd0, wmem[16'h2002]}, 32'hAB);

        // 3: 1-byte read, then 2-byte read wrapping the address space
        mem_we_i = 0; mem_len_i = 2'b00; mem_addr_i = 32'h30;
        mem_req_i = 1; tick(); mem_req_i = 0;
        wait_done(10, n);
        chk("t3_lat", 32'(n), 2);
        chk("t3_rdata", mem_rdata_o, 32'h00000080);
        tick();
        mem_len_i = 2'b01; mem_addr_i = 32'hFFFFFFFF;
        mem_req_i = 1; tick(); mem_req_i = 0;
        chk("t3_wa0", ram_a_o, 32'hFFFFFFFF);
        tick();
        chk("t3_wa1", ram_a_o, 32'h0);
        wait_done(10, n);
        chk("t3_wlat", 32'(n), 2);
        chk("t3_wrdata", mem_rdata_o, 32'h00002211);
        chk("t3_insthold", if_inst_o, 32'h00000513);
        tick();

        // 5: cancel a fetch after E2; pending MEM then granted
        if_addr_i = 32'h1000; if_req_i = 1; tick(); if_req_i = 0;
        mem_len_i = 2'b00; mem_addr_i = 32'h30; mem_req_i = 1;
        tick(); tick();
        if_cancel_i = 1; tick();
        chk("t5_idle", 32'(busy_o), 0);
        chk("t5_noifdone", 32'(if_done_o), 0);
        chk("t5_ahold", ram_a_o, 32'h1002);
        tick();
        chk("t5_memgrant", ram_a_o, 32'h30);
        mem_req_i = 0;
        wait_done(10, n);
        chk("t5_memlat", 32'(n), 2);
        chk("t5_rdata", {31'd0, if_done_o} | {mem_rdata_o[30:0], 1'b0}, 32'h100);
        tick();
        if_req_i = 1; tick();
        chk("t5_noaccept", 32'(busy_o), 0);
        if_req_i = 0; if_cancel_i = 0;

        // reset restores last_grant before the arbitration sequence
        rst = 1'b0; tick();
        chk("rst2_rdata", mem_rdata_o, 0);
        chk("rst2_inst", if_inst_o, 0);
        rst = 1'b1; tick();

        // 4: both requesting repeatedly -> MEM, IF, MEM, IF
        if_addr_i = 32'h1000; if_req_i = 1;
        mem_we_i = 0; mem_len_i = 2'b00; mem_addr_i = 32'h30; mem_req_i = 1;
        tick();
        chk("t4_g1_mem", ram_a_o, 32'h30);
        mem_req_i = 0;
        wait_done(10, n);
        chk("t4_d1", 32'(mem_done_o), 1);
        tick();
        mem_req_i = 1; tick();
        chk("t4_g2_if", ram_a_o, 32'h1000);
        wait_done(10, n);
        chk("t4_d2", 32'(if_done_o), 1);
        if_req_i = 0; tick();
        if_req_i = 1; tick();
        chk("t4_g3_mem", ram_a_o, 32'h30);
        mem_req_i = 0;
        wait_done(10, n);
        tick();
        mem_req_i = 1; tick();
        chk("t4_g4_if", ram_a_o, 32'h1000);
        mem_req_i = 0; if_req_i = 0;
        wait_done(10, n);
        chk("t4_d4", 32'(if_done_o), 1);
        tick();

        // 6: stall mid fetch, stall mid write, reset mid write
        if_addr_i = 32'h1000; if_req_i = 1; tick(); if_req_i = 0;
        tick(); tick();
        rdy = 0;
        repeat (3) tick();
        chk("t6_afrozen", ram_a_o, 32'h1002);
        chk("t6_nowr", 32'(ram_wr_o), 0);
        rdy = 1;
        wait_done(10, n);
        chk("t6_lat", 32'(n), 3);
        chk("t6_inst", if_inst_o, 32'h00000513);
        tick();

        mem_we_i = 1; mem_len_i = 2'b00; mem_addr_i = 32'h2100; mem_wdata_i = 32'h0000005A;
        w0 = wr_cnt; mem_req_i = 1; tick(); mem_req_i = 0;
        chk("t6_wr", 32'(ram_wr_o), 1);
        rdy = 0; #1;
        chk("t6_gate", 32'(ram_wr_o), 0);
        tick();
        chk("t6_stalldone", 32'(mem_done_o), 0);
        rdy = 1; #1;
        chk("t6_ungate", 32'(ram_wr_o), 1);
        tick();
        chk("t6_wdone", 32'(mem_done_o), 1);
        tick();
        chk("t6_wcnt", 32'(wr_cnt - w0), 1);
        chk("t6_m2100", {24'd0, wmem[16'h2100]}, 32'h5A);

        mem_len_i = 2'b11; mem_addr_i = 32'h2200; mem_wdata_i = 32'h11223344;
        mem_req_i = 1; tick(); mem_req_i = 0;
        tick();
        chk("t6_midwr", {23'd0, ram_wr_o, ram_dout_o}, {23'd0, 1'b1, 8'h33});
        rst = 1'b0; tick();
        chk("t6_rst_wr", 32'(ram_wr_o), 0);
        chk("t6_rst_busy", 32'(busy_o), 0);
        chk("t6_rst_a", ram_a_o, 0);
        chk("t6_rst_dout", {24'd0, ram_dout_o}, 0);
        chk("t6_rst_outs", {30'd0, if_done_o, mem_done_o} | if_inst_o | mem_rdata_o, 0);
        rst = 1'b1; tick();
        chk("t6_after", 32'(busy_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single byte-wide RAM port and shares it between instruction fetch (IF, 4-byte reads) and the load/store unit (MEM, 1/2/4-byte reads and writes).
- Sits between the IF/MEM stages and the external RAM bus.
- Splits each multi-byte access into consecutive byte cycles and assembles or disassembles words little-endian.
- Arbitrates by alternating priority and supports aborting an in-flight fetch on a taken jump.

Parameters:
ADDR_W, 32, address width of requesters and RAM port
DATA_W, 32, requester data width (fixed at 4 bytes)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
rdy  in  1  global ready; low freezes the block
if_req_i  in  1  IF requests a 4-byte read
if_addr_i  in  ADDR_W  fetch address
if_cancel_i  in  1  abort the current or pending fetch (jump)
if_done_o  out  1  one-cycle pulse; if_inst_o valid
if_inst_o  out  DATA_W  fetched instruction
mem_req_i  in  1  MEM requests an access
mem_we_i  in  1  1 = write, 0 = read
mem_len_i  in  2  00 = 1B, 01 = 2B, 11 = 4B, 10 = reserved (treated as 4B)
mem_addr_i  in  ADDR_W  access base address
mem_wdata_i  in  DATA_W  store data; low bytes used
mem_done_o  out  1  one-cycle pulse; access complete, mem_rdata_o valid on reads
mem_rdata_o  out  DATA_W  load data, zero-extended
ram_din_i  in  8  byte from RAM
ram_dout_o  out  8  byte to RAM
ram_a_o  out  ADDR_W  RAM address
ram_wr_o  out  1  RAM write strobe
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst == 0 at a clk edge): state = IDLE; all outputs 0; last_grant = IF. Takes effect even mid-transaction; a partial write is abandoned with ram_wr_o = 0 after that edge.
- rdy == 0: every register holds its value. ram_wr_o is gated to 0 combinationally. The RAM is paused by the same rdy, so latency simply stretches by the number of stalled cycles.
- RAM contract: the address and write data driven after edge E are consumed by the RAM at E+1. The read byte is valid on ram_din_i after E+1 and captured by this block at E+2.
- States: IDLE, READ, WRITE, DONE.
- IDLE accepts a request at edge E0:
  - Only MEM requesting: grant MEM.
  - Only IF requesting and if_cancel_i == 0: grant IF.
  - Both requesting: grant the requester not equal to last_grant, then update last_grant.
  - An IF request with if_cancel_i == 1 is not accepted.
- On grant, base, length N, write flag and owner are latched; requester inputs are ignored until DONE.
- READ of N bytes:
  - ram_a_o = base + k at edge Ek for k = 0..N-1 (32-bit modulo wrap).
  - Byte k is captured at E(k+2) into bits [8k+7:8k].
  - Data and done pulse are registered at E(N+1); state moves to DONE.
  - Result: 4B read done at E5, 1B read done at E2.
- WRITE of N bytes:
  - At Ek (k = 0..N-1): ram_a_o = base + k, ram_dout_o = wdata[8k+7:8k], ram_wr_o = 1.
  - At EN: ram_wr_o = 0, mem_done_o = 1, state moves to DONE.
- DONE: lasts one cycle with the done pulse high; no acceptance this cycle; returns to IDLE. Requesters drop their req while done is high.
- Unused high bytes of mem_rdata_o are 0; sign extension is done by the LSU. if_inst_o and mem_rdata_o hold their values until the next completion of the same owner.
- if_cancel_i:
  - While an IF READ is in progress: at the next edge go to IDLE, no if_done_o, in-flight bytes discarded, ram_a_o unchanged.
  - Ignored during MEM transactions and during DONE; a done pulse already issued stands.
- ram_wr_o is never high outside WRITE.

Test Plan:
1. IF read at 0x1000, RAM bytes 13 05 00 00 -> if_done_o pulses after E5 with if_inst_o = 0x00000513; ram_a_o steps 0x1000..0x1003.
2. MEM write len = 01, addr 0x2001, wdata 0xFFFFABCD -> writes CD @0x2001, AB @0x2002; ram_wr_o high exactly 2 cycles; mem_done_o after E2.
3. MEM read len = 00 at 0x30, byte 0x80 -> mem_rdata_o = 0x00000080 after E2. Address 0xFFFFFFFF read as 2B -> second address 0x00000000.
4. if_req and mem_req asserted together twice in a row -> grant order MEM, IF, then MEM, IF; never two consecutive MEM grants while IF is waiting.
5. if_cancel_i asserted after E2 of a fetch -> IDLE next edge, no if_done_o. A pending mem_req is granted at the following edge.
6. rdy low for 3 cycles mid 4B read -> identical data, done 3 cycles later, ram_wr_o = 0. rst low mid write -> all outputs 0 and busy_o = 0 after that edge.
